vend_dispense_ctrl: RTL

- Consumer side of the vending FSM's `out`/`change` interface.
- Captures each dispense request (product and/or change) into a small FIFO, then runs the product motor and the 5 Rs coin hopper through done/ack handshakes.
- Provides timeout fault detection and wrapping activity counters.
- Sits between the vending FSM and the electromechanical drivers.

---
 rtl/vend_dispense_ctrl.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/vend_dispense_ctrl.sv
// Dispense sequencer: queues product/change requests from the vending FSM and
// drives the product motor and 5 Rs coin hopper through done/ack handshakes.
module vend_dispense_ctrl #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255,
    parameter int PULSE_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vend_out,
    input  logic [1:0]  vend_change,
    input  logic        motor_done,
    input  logic        hopper_ack,
    input  logic        fault_clr,
    output logic        motor_en,
    output logic        hopper_pulse,
    output logic        busy,
    output logic        fault,
    output logic        overflow,
    output logic [15:0] vend_count,
    output logic [15:0] coin_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int PW = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_VEND  = 3'd1;
    localparam logic [2:0] S_COIN  = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_FAULT = 3'd4;

    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT);
    localparam logic [TW-1:0] TMR_ONE    = TW'(1);
    localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_W - 1);
    localparam logic [PW-1:0] PCNT_ONE   = PW'(1);
    localparam logic [AW:0]   CNT_FULL   = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE    = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);

    logic [2:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          overflow_q, overflow_d;
    logic [2:0]    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [1:0]    coins_q, coins_d;
    logic [15:0]   vend_count_q, vend_count_d;
    logic [15:0]   coin_count_q, coin_count_d;

    logic [1:0] req_coins_s;
    logic       req_s, empty_s, full_s, pop_s, push_ok_s, drop_s;
    logic [2:0] head_s;

    // Request decode and FIFO bookkeeping; a full FIFO still accepts when IDLE pops the same cycle
    always_comb begin
        case (vend_change)
            2'b01:   req_coins_s = 2'd1;
            2'b10:   req_coins_s = 2'd2;
            default: req_coins_s = 2'd0;
        endcase
        req_s     = vend_out | (req_coins_s != 2'd0);
        empty_s   = (cnt_q == '0);
        full_s    = (cnt_q == CNT_FULL);
        head_s    = mem_q[rd_ptr_q];
        pop_s     = (state_q == S_IDLE) && !empty_s;
        push_ok_s = req_s && (!full_s || pop_s);
        drop_s    = req_s && full_s && !pop_s;

        wr_ptr_d   = push_ok_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d   = pop_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        overflow_d = overflow_q | drop_s;
        case ({push_ok_s, pop_s})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
    end

    // Sequencer next-state; a done/ack in the terminal timer cycle takes priority over the fault
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        pcnt_d       = pcnt_q;
        coins_d      = coins_q;
        vend_count_d = vend_count_q;
        coin_count_d = coin_count_q;
        case (state_q)
            S_IDLE: begin
                if (pop_s) begin
                    coins_d = head_s[1:0];
                    if (head_s[2]) begin
                        state_d = S_VEND;
                        timer_d = '0;
                    end else begin
                        state_d = S_COIN;
                        pcnt_d  = '0;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_VEND: begin
                if (motor_done) begin
                    vend_count_d = vend_count_q + 16'd1;
                    pcnt_d       = '0;
                    state_d      = (coins_q != 2'd0) ? S_COIN : S_IDLE;
                end else if (timer_q == TMO_LAST) begin
                    state_d = S_FAULT;
                end else begin
                    timer_d = timer_q + TMR_ONE;
                end
            end
            S_COIN: begin
                if (pcnt_q == PULSE_LAST) begin
                    state_d = S_WAIT;
                    timer_d = '0;
                end else begin
                    pcnt_d = pcnt_q + PCNT_ONE;
                end
            end
            S_WAIT: begin
                if (hopper_ack) begin
                    coin_count_d = coin_count_q + 16'd1;
                    coins_d      = coins_q - 2'd1;
                    pcnt_d       = '0;
                    state_d      = (coins_q > 2'd1) ? S_COIN : S_IDLE;
                end else if (timer_q == TMO_LAST) begin
                    state_d = S_FAULT;
                end else begin
                    timer_d = timer_q + TMR_ONE;
                end
            end
            S_FAULT: begin
                coins_d = 2'd0;
                state_d = fault_clr ? S_IDLE : S_FAULT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Request storage; entries are never cleared, only the pointers and count reset
    always_ff @(posedge clk) begin
        if (!rst && push_ok_s) begin
            mem_q[wr_ptr_q] <= {vend_out, req_coins_s};
        end
    end

    // State, FIFO control and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            overflow_q   <= 1'b0;
            state_q      <= S_IDLE;
            timer_q      <= '0;
            pcnt_q       <= '0;
            coins_q      <= 2'd0;
            vend_count_q <= 16'd0;
            coin_count_q <= 16'd0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            overflow_q   <= overflow_d;
            state_q      <= state_d;
            timer_q      <= timer_d;
            pcnt_q       <= pcnt_d;
            coins_q      <= coins_d;
            vend_count_q <= vend_count_d;
            coin_count_q <= coin_count_d;
        end
    end

    // Drive outputs decode from flops only so no input can glitch them
    assign motor_en     = (state_q == S_VEND);
    assign hopper_pulse = (state_q == S_COIN);
    assign fault        = (state_q == S_FAULT);
    assign busy         = (state_q != S_IDLE) || (cnt_q != '0);
    assign overflow     = overflow_q;
    assign vend_count   = vend_count_q;
    assign coin_count   = coin_count_q;

endmodule
